// File: rtl/armleocpu_ptw.sv
// armleocpu_ptw: Sv32 hardware page-table walker feeding armleocpu_tlb.
// Walks at most two levels of 4-byte PTEs and returns a 22-bit PPN plus
// the leaf's 8 access bits, or a page/access fault. Results are formatted
// for the TLB write port.
//
// Ports:
//   clk, rst                  clock, asynchronous active-high reset
//   resolve_request           start a walk (sampled only when idle)
//   virtual_address[19:0]     VPN1 = [19:10], VPN0 = [9:0]
//   satp_ppn[21:0]            root page-table PPN
//   resolve_done              one-cycle completion pulse
//   resolve_pagefault         page fault, valid with resolve_done
//   resolve_accessfault       bus error during walk, valid with resolve_done
//   resolve_physical_address  resulting PPN (zero on fault)
//   resolve_access_bits       leaf PTE[7:0] (zero on fault)
//   mem_read/mem_address      PTE read request, held until mem_done
//   mem_done/mem_error/mem_readdata  read response
module armleocpu_ptw (
  input  logic        clk,
  input  logic        rst,
  input  logic        resolve_request,
  input  logic [19:0] virtual_address,
  input  logic [21:0] satp_ppn,
  output logic        resolve_done,
  output logic        resolve_pagefault,
  output logic        resolve_accessfault,
  output logic [21:0] resolve_physical_address,
  output logic [7:0]  resolve_access_bits,
  output logic        mem_read,
  output logic [33:0] mem_address,
  input  logic        mem_done,
  input  logic        mem_error,
  input  logic [31:0] mem_readdata
);

  typedef enum logic [1:0] {
    IDLE,
    READ,
    DONE
  } state_t;

  state_t      state_q;
  logic        level_q;
  logic [9:0]  vpn0_q;

  logic        pte_v, pte_r, pte_w, pte_x;
  logic        pte_invalid, pte_leaf, pte_misaligned;
  logic        unused_rsw;

  always_comb begin
    pte_v          = mem_readdata[0];
    pte_r          = mem_readdata[1];
    pte_w          = mem_readdata[2];
    pte_x          = mem_readdata[3];
    pte_invalid    = !pte_v || (!pte_r && pte_w);
    pte_leaf       = pte_r || pte_x;
    // A first-level leaf must describe a 4 MiB-aligned megapage.
    pte_misaligned = level_q && (mem_readdata[19:10] != 10'd0);
  end

  // RSW bits carry no meaning for the walker.
  assign unused_rsw = ^mem_readdata[9:8];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q                  <= IDLE;
      level_q                  <= 1'b1;
      vpn0_q                   <= '0;
      resolve_done             <= 1'b0;
      resolve_pagefault        <= 1'b0;
      resolve_accessfault      <= 1'b0;
      resolve_physical_address <= '0;
      resolve_access_bits      <= '0;
      mem_read                 <= 1'b0;
      mem_address              <= '0;
    end else begin
      resolve_done <= 1'b0;
      case (state_q)
        IDLE: begin
          if (resolve_request) begin
            vpn0_q                   <= virtual_address[9:0];
            level_q                  <= 1'b1;
            mem_read                 <= 1'b1;
            mem_address              <= {satp_ppn, virtual_address[19:10], 2'b00};
            resolve_pagefault        <= 1'b0;
            resolve_accessfault      <= 1'b0;
            resolve_physical_address <= '0;
            resolve_access_bits      <= '0;
            state_q                  <= READ;
          end
        end
        READ: begin
          if (mem_done) begin
            if (!mem_error && !pte_invalid && !pte_leaf && level_q) begin
              // Pointer at level 1: next address issued back-to-back.
              level_q     <= 1'b0;
              mem_address <= {mem_readdata[31:10], vpn0_q, 2'b00};
            end else begin
              mem_read     <= 1'b0;
              resolve_done <= 1'b1;
              state_q      <= DONE;
              if (mem_error) begin
                resolve_accessfault <= 1'b1;
              end else if (pte_invalid || !pte_leaf || pte_misaligned) begin
                resolve_pagefault <= 1'b1;
              end else begin
                resolve_access_bits <= mem_readdata[7:0];
                if (level_q) begin
                  resolve_physical_address <= {mem_readdata[31:20], vpn0_q};
                end else begin
                  resolve_physical_address <= mem_readdata[31:10];
                end
              end
            end
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_armleocpu_ptw.sv
module tb_armleocpu_ptw;

  logic        clk = 1'b0;
  logic        rst;
  logic        resolve_request;
  logic [19:0] virtual_address;
  logic [21:0] satp_ppn;
  logic        resolve_done;
  logic        resolve_pagefault;
  logic        resolve_accessfault;
  logic [21:0] resolve_physical_address;
  logic [7:0]  resolve_access_bits;
  logic        mem_read;
  logic [33:0] mem_address;
  logic        mem_done;
  logic        mem_error;
  logic [31:0] mem_readdata;

  armleocpu_ptw dut (
    .clk                      (clk),
    .rst                      (rst),
    .resolve_request          (resolve_request),
    .virtual_address          (virtual_address),
    .satp_ppn                 (satp_ppn),
    .resolve_done             (resolve_done),
    .resolve_pagefault        (resolve_pagefault),
    .resolve_accessfault      (resolve_accessfault),
    .resolve_physical_address (resolve_physical_address),
    .resolve_access_bits      (resolve_access_bits),
    .mem_read                 (mem_read),
    .mem_address              (mem_address),
    .mem_done                 (mem_done),
    .mem_error                (mem_error),
    .mem_readdata             (mem_readdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [21:0] satp;
    logic [19:0] va;
    logic [31:0] pte0;
    logic [31:0] pte1;
    int          err_at;  // 0: none, 1: first read errors, 2: second read errors
    int          waits;
    bit          busy;
    int          nreads;
    logic [33:0] a0;
    logic [33:0] a1;
    bit          pf;
    bit          af;
    logic [21:0] ppn;
    logic [7:0]  bits;
  } vec_t;

  int unsigned n_checks = 0;
  int unsigned n_pass = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Reference walk computed straight from the Sv32 rules with integer math.
  function automatic vec_t model(input vec_t v);
    longint unsigned tbl, idx, addr, pte;
    bit pv, pr, pw, px;
    v.nreads = 0; v.pf = 0; v.af = 0; v.ppn = '0; v.bits = '0; v.a0 = '0; v.a1 = '0;
    tbl = longint'(v.satp);
    for (int lvl = 1; lvl >= 0; lvl--) begin
      idx  = (lvl == 1) ? (longint'(v.va) / 1024) : (longint'(v.va) % 1024);
      addr = tbl * 4096 + idx * 4;
      if (lvl == 1) v.a0 = 34'(addr); else v.a1 = 34'(addr);
      v.nreads++;
      pte = (lvl == 1) ? longint'(v.pte0) : longint'(v.pte1);
      if (v.err_at == v.nreads) begin v.af = 1; return v; end
      pv = pte[0]; pr = pte[1]; pw = pte[2]; px = pte[3];
      if (!pv || (!pr && pw)) begin v.pf = 1; return v; end
      if (pr || px) begin
        if (lvl == 1) begin
          if ((pte / 1024) % 1024 != 0) begin v.pf = 1; return v; end
          v.ppn = 22'((pte / (1 << 20)) * 1024 + longint'(v.va) % 1024);
        end else begin
          v.ppn = 22'(pte / 1024);
        end
        v.bits = 8'(pte % 256);
        return v;
      end
      if (lvl == 0) begin v.pf = 1; return v; end
      tbl = pte / 1024;
    end
    return v;
  endfunction

  task automatic run_walk(input string tag, input vec_t v);
    logic [33:0] cur, g_a0, g_a1;
    int cyc, n, wcnt, unstable, gaps;
    bit done, g_pf, g_af;
    logic [21:0] g_ppn;
    logic [7:0]  g_bits;
    cur = '0; g_a0 = '0; g_a1 = '0; g_pf = 0; g_af = 0; g_ppn = '0; g_bits = '0;
    @(negedge clk);
    resolve_request = 1'b1; virtual_address = v.va; satp_ppn = v.satp;
    @(negedge clk);
    resolve_request = 1'b0;
    cyc = 1; n = 0; wcnt = 0; unstable = 0; gaps = 0; done = 0;
    while (!done && cyc < 200) begin
      mem_done = 1'b0; mem_error = 1'b0;
      if (resolve_done) begin
        done = 1;
        g_pf = resolve_pagefault; g_af = resolve_accessfault;
        g_ppn = resolve_physical_address; g_bits = resolve_access_bits;
      end else begin
        if (v.busy && cyc == 1) begin
          resolve_request = 1'b1; virtual_address = ~v.va; satp_ppn = ~v.satp;
        end else begin
          resolve_request = 1'b0;
        end
        if (mem_read) begin
          if (wcnt == 0) begin
            cur = mem_address;
            if (n == 0) g_a0 = cur; else if (n == 1) g_a1 = cur;
          end else if (mem_address !== cur) begin
            unstable++;
          end
          if (wcnt == v.waits) begin
            mem_done = 1'b1;
            mem_readdata = (n == 0) ? v.pte0 : (n == 1) ? v.pte1 : 32'h0;
            mem_error = (v.err_at == n + 1);
            n++; wcnt = 0;
          end else begin
            wcnt++;
          end
        end else begin
          gaps++;
        end
        @(negedge clk);
        cyc++;
      end
    end
    mem_done = 1'b0; mem_error = 1'b0; resolve_request = 1'b0;
    if (!done) begin
      check({tag, " timeout"}, 64'd0, 64'd1);
      rst = 1'b1; @(negedge clk); rst = 1'b0;
      return;
    end
    check({tag, " nreads"}, 64'(n), 64'(v.nreads));
    check({tag, " addr0"}, 64'(g_a0), 64'(v.a0));
    if (v.nreads == 2) check({tag, " addr1"}, 64'(g_a1), 64'(v.a1));
    check({tag, " pagefault"}, 64'(g_pf), 64'(v.pf));
    check({tag, " accessfault"}, 64'(g_af), 64'(v.af));
    check({tag, " ppn"}, 64'(g_ppn), 64'(v.ppn));
    check({tag, " bits"}, 64'(g_bits), 64'(v.bits));
    check({tag, " latency"}, 64'(cyc), 64'(v.nreads * (v.waits + 1) + 1));
    check({tag, " addr_stable"}, 64'(unstable), 64'd0);
    check({tag, " read_gaps"}, 64'(gaps), 64'd0);
    @(negedge clk);
    check({tag, " done_pulse_ends"}, 64'(resolve_done), 64'd0);
    check({tag, " read_idle"}, 64'(mem_read), 64'd0);
  endtask

  function automatic vec_t mk(input logic [21:0] satp, input logic [19:0] va,
                              input logic [31:0] p0, input logic [31:0] p1,
                              input int err_at, input int waits, input bit busy,
                              input int nreads, input logic [33:0] a0, input logic [33:0] a1,
                              input bit pf, input bit af, input logic [21:0] ppn,
                              input logic [7:0] bits);
    vec_t v;
    v.satp = satp; v.va = va; v.pte0 = p0; v.pte1 = p1; v.err_at = err_at;
    v.waits = waits; v.busy = busy; v.nreads = nreads; v.a0 = a0; v.a1 = a1;
    v.pf = pf; v.af = af; v.ppn = ppn; v.bits = bits;
    return v;
  endfunction

  function automatic logic [31:0] rand_pte();
    logic [31:0] p;
    logic [7:0]  lo;
    p = $urandom;
    case ($urandom_range(0, 5))
      0: lo = 8'h01;
      1: lo = 8'hCF;
      2: lo = 8'hCB;
      3: lo = 8'h05;
      4: lo = 8'h00;
      default: lo = 8'($urandom);
    endcase
    p[7:0] = lo;
    if ($urandom_range(0, 1) == 1) p[19:10] = '0;
    return p;
  endfunction

  vec_t vecs[9];
  vec_t rv;
  int   e;

  initial begin
    rst = 1'b1; resolve_request = 1'b0; virtual_address = '0; satp_ppn = '0;
    mem_done = 1'b0; mem_error = 1'b0; mem_readdata = '0;

    vecs[0] = mk(22'h1, 20'h2_0000, 32'h0000_0801, 32'h0400_00CF, 0, 0, 0, 2, 34'h1200, 34'h2000, 0, 0, 22'h1_0000, 8'hCF);
    vecs[1] = mk(22'h1, 20'h2_0003, 32'h0050_00CB, 32'h0, 0, 0, 0, 1, 34'h1200, 34'h0, 0, 0, 22'h0_1403, 8'hCB);
    vecs[2] = mk(22'h1, 20'h2_0000, 32'h0, 32'h0, 0, 0, 0, 1, 34'h1200, 34'h0, 1, 0, 22'h0, 8'h00);
    vecs[3] = mk(22'h1, 20'h2_0003, 32'h0050_04CB, 32'h0, 0, 0, 0, 1, 34'h1200, 34'h0, 1, 0, 22'h0, 8'h00);
    vecs[4] = mk(22'h1, 20'h2_0000, 32'h0000_0801, 32'h0000_0801, 0, 0, 0, 2, 34'h1200, 34'h2000, 1, 0, 22'h0, 8'h00);
    vecs[5] = mk(22'h1, 20'h2_0000, 32'h0000_0005, 32'h0, 0, 0, 0, 1, 34'h1200, 34'h0, 1, 0, 22'h0, 8'h00);
    vecs[6] = mk(22'h1, 20'h2_0000, 32'h0000_0801, 32'h0400_00CF, 2, 0, 0, 2, 34'h1200, 34'h2000, 0, 1, 22'h0, 8'h00);
    vecs[7] = mk(22'h1, 20'h2_0000, 32'h0000_0801, 32'h0400_00CF, 0, 5, 0, 2, 34'h1200, 34'h2000, 0, 0, 22'h1_0000, 8'hCF);
    vecs[8] = mk(22'h1, 20'h2_0003, 32'h0050_00CB, 32'h0, 0, 5, 1, 1, 34'h1200, 34'h0, 0, 0, 22'h0_1403, 8'hCB);

    // Reset state
    repeat (2) @(negedge clk);
    check("reset done", 64'(resolve_done), 64'd0);
    check("reset mem_read", 64'(mem_read), 64'd0);
    check("reset mem_address", 64'(mem_address), 64'd0);
    check("reset results", 64'({resolve_pagefault, resolve_accessfault, resolve_physical_address, resolve_access_bits}), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    check("idle no read", 64'(mem_read), 64'd0);

    for (int i = 0; i < 9; i++) run_walk($sformatf("vec%0d", i), vecs[i]);

    // Reset while a read is outstanding, then a stray mem_done in idle
    @(negedge clk);
    resolve_request = 1'b1; virtual_address = 20'h2_0000; satp_ppn = 22'h1;
    @(negedge clk);
    resolve_request = 1'b0;
    check("midwalk read", 64'(mem_read), 64'd1);
    rst = 1'b1;
    #1;
    check("midwalk rst read drop", 64'(mem_read), 64'd0);
    check("midwalk rst outputs", 64'({resolve_done, resolve_pagefault, resolve_accessfault, mem_address}), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    mem_done = 1'b1; mem_readdata = 32'h0400_00CF;
    @(negedge clk);
    mem_done = 1'b0;
    e = 0;
    repeat (3) begin
      if (resolve_done || mem_read) e++;
      @(negedge clk);
    end
    check("late mem_done ignored", 64'(e), 64'd0);
    run_walk("post_reset", vecs[0]);

    // Randomised walks against the reference model
    for (int i = 0; i < 60; i++) begin
      rv.satp = 22'($urandom);
      rv.va = 20'($urandom);
      rv.pte0 = rand_pte();
      rv.pte1 = rand_pte();
      e = $urandom_range(0, 5);
      rv.err_at = (e > 2) ? 0 : e;
      rv.waits = $urandom_range(0, 2);
      rv.busy = 1'($urandom_range(0, 1));
      rv = model(rv);
      run_walk($sformatf("rand%0d", i), rv);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
